elastic_pipe: RTL and testbench

Valid/ready pipeline of configurable depth that carries a WIDTH-bit word stream from a producer to a consumer that may apply backpressure. It sits on the consuming side of the packet-to-book datapath, where `pipe` cannot be used because a downstream stage can stall. It is registered on both the data path and the upstream ready, so it breaks timing on both directions of the handshake. It collapses bubbles, preserves order, and never drops or duplicates words.

---
 rtl/elastic_pipe.sv | 115 +++++++++++
 tb/tb_elastic_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe.sv
// elastic_pipe: valid/ready pipeline of DEPTH main stages plus one input skid register.
// Upstream ready and occupancy are registered; bubbles collapse, order is preserved.
module elastic_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                            clkIn,
  input  logic                            rstIn,
  input  logic                            inValidIn,
  output logic                            inReadyOut,
  input  logic [WIDTH-1:0]                inDataIn,
  output logic                            outValidOut,
  input  logic                            outReadyIn,
  output logic [WIDTH-1:0]                outDataOut,
  output logic [$clog2(DEPTH+2)-1:0]      countOut
);

  localparam int CW = $clog2(DEPTH + 2);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "elastic_pipe: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "elastic_pipe: WIDTH must be >= 1");
  end

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             ready_q;
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0] adv;
  logic             in_hs;
  logic             out_hs;
  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             skid_set;
  logic             skid_clr;
  logic             skid_valid_d;

  // Advance chain: stage i may load when it or any stage after it is empty, or the consumer
  // takes the last word. Built as a running AND so there is no self-referencing vector.
  always_comb begin
    logic full_run;
    full_run = 1'b1;
    adv      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_run = full_run & valid_q[i];
      adv[i]   = outReadyIn | ~full_run;
    end
  end

  assign in_hs  = inValidIn & ready_q;
  assign out_hs = valid_q[DEPTH-1] & outReadyIn;

  // Stage 0 drains the skid first so older words stay ahead of the port.
  assign src_valid = skid_valid_q | in_hs;
  assign src_data  = skid_valid_q ? skid_data_q : inDataIn;

  // Skid captures a word only when stage 0 cannot move; while it holds one, ready is low,
  // so set and clear are mutually exclusive.
  assign skid_set     = in_hs & ~adv[0];
  assign skid_clr     = skid_valid_q & adv[0];
  assign skid_valid_d = skid_set | (skid_valid_q & ~skid_clr);

  // Main stages: shift forward wherever the advance chain allows.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid_q[0] <= src_valid;
        data_q[0]  <= src_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end
  end

  // Skid register, registered upstream ready and occupancy counter.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      if (skid_set) begin
        skid_data_q <= inDataIn;
      end
      ready_q <= ~skid_valid_d;
      unique case ({in_hs, out_hs})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign inReadyOut  = ready_q;
  assign outValidOut = valid_q[DEPTH-1];
  assign outDataOut  = data_q[DEPTH-1];
  assign countOut    = count_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: three elastic_pipe instances (DEPTH 3, 1, 4; WIDTH 8) checked every
// cycle against a queue-based model, plus literal expectations on the DEPTH=3 instance.
module tb_elastic_pipe;

  localparam int N = 3;
  localparam int W = 8;

  function automatic int dep_of(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 1 : 4);
  endfunction

  typedef struct {
    logic [W-1:0] d;
    int           e;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]        iv;
  logic [N-1:0]        ordy;
  logic [N-1:0][W-1:0] id;
  logic [N-1:0]        irdy;
  logic [N-1:0]        ov;
  logic [N-1:0][W-1:0] od;
  logic [N-1:0][3:0]   cnt;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D  = dep_of(g);
    localparam int CW = $clog2(D + 2);
    logic [CW-1:0] c;

    elastic_pipe #(.DEPTH(D), .WIDTH(W)) u_dut (
      .clkIn      (clk),
      .rstIn      (rst),
      .inValidIn  (iv[g]),
      .inReadyOut (irdy[g]),
      .inDataIn   (id[g]),
      .outValidOut(ov[g]),
      .outReadyIn (ordy[g]),
      .outDataOut (od[g]),
      .countOut   (c)
    );
    assign cnt[g] = 4'(c);

    // Edge sampling: what happened at this rising edge, seen from pre-edge values.
    logic         hs_in   = 1'b0;
    logic         hs_out  = 1'b0;
    logic         rst_e   = 1'b1;
    logic         stall_e = 1'b0;
    logic [W-1:0] din     = '0;
    logic [W-1:0] stall_d = '0;
    always @(posedge clk) begin
      hs_in   <= iv[g] & irdy[g];
      hs_out  <= ov[g] & ordy[g];
      din     <= id[g];
      rst_e   <= rst;
      stall_e <= ov[g] & ~ordy[g];
      stall_d <= od[g];
    end

    // Model: words in flight, each tagged with its acceptance edge. The oldest word shows
    // on the output once it has had D-1 further edges to travel; ready is low only when
    // the block holds D+1 words.
    ent_t q[$];
    int   ecount = 0;
    bit   rdy_ok = 1'b0;
    always @(negedge clk) begin
      bit exp_v;
      if (rst_e || rst) begin
        q.delete();
        rdy_ok = 1'b0;
      end else begin
        ecount++;
        if (hs_out) begin
          chk($sformatf("pop_nonempty[%0d]", g), int'(q.size() > 0), 1);
          if (q.size() > 0) void'(q.pop_front());
        end
        if (hs_in) begin
          q.push_back('{d: din, e: ecount});
          chk($sformatf("capacity[%0d]", g), int'(q.size() <= D + 1), 1);
        end
        rdy_ok = 1'b1;
      end
      if (rst) begin
        chk($sformatf("rst_valid[%0d]", g), int'(ov[g]), 0);
        chk($sformatf("rst_data[%0d]", g), int'(od[g]), 0);
        chk($sformatf("rst_count[%0d]", g), int'(cnt[g]), 0);
        chk($sformatf("rst_ready[%0d]", g), int'(irdy[g]), 0);
      end else begin
        chk($sformatf("count[%0d]", g), int'(cnt[g]), q.size());
        chk($sformatf("ready[%0d]", g), int'(irdy[g]), int'(rdy_ok && q.size() != D + 1));
        exp_v = (q.size() > 0) && (ecount - q[0].e >= D - 1);
        chk($sformatf("out_valid[%0d]", g), int'(ov[g]), int'(exp_v));
        if (exp_v) chk($sformatf("out_data[%0d]", g), int'(od[g]), int'(q[0].d));
        if (stall_e && !rst_e) begin
          chk($sformatf("stall_valid[%0d]", g), int'(ov[g]), 1);
          chk($sformatf("stall_data[%0d]", g), int'(od[g]), int'(stall_d));
        end
      end
    end
  end

  logic [N-1:0] rdy_seen;
  int pin, pout;

  initial begin
    iv = '0; id = '0; ordy = '1; rdy_seen = '0;
    iv[0] = 1'b1; id[0] = 8'hAA;

    // Reset with a word offered.
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(ov[0]), 0);
    chk("reset_data", int'(od[0]), 0);
    chk("reset_count", int'(cnt[0]), 0);
    chk("reset_ready", int'(irdy[0]), 0);
    #1 rst = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(irdy[0]), 1);

    // Latency: word offered before edge 1 is visible after edge 3.
    #1 iv[0] = 1'b1; id[0] = 8'h5A; ordy[0] = 1'b1;
    @(negedge clk);
    chk("lat_e1_valid", int'(ov[0]), 0);
    #1 iv[0] = 1'b0;
    @(negedge clk);
    chk("lat_e2_valid", int'(ov[0]), 0);
    @(negedge clk);
    chk("lat_e3_valid", int'(ov[0]), 1);
    chk("lat_e3_data", int'(od[0]), 8'h5A);
    @(negedge clk);
    chk("lat_e4_valid", int'(ov[0]), 0);
    chk("lat_e4_count", int'(cnt[0]), 0);

    // Fill under stall, then drain.
    #1 ordy[0] = 1'b0; iv[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      id[0] = 8'(k);
      @(negedge clk);
      #1;
    end
    iv[0] = 1'b0;
    chk("fill_count", int'(cnt[0]), 4);
    chk("fill_ready", int'(irdy[0]), 0);
    chk("fill_valid", int'(ov[0]), 1);
    chk("fill_data", int'(od[0]), 1);
    repeat (2) @(negedge clk);
    chk("hold_data", int'(od[0]), 1);
    #1 ordy[0] = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("drain_data", int'(od[0]), k);
      if (k == 2) chk("drain_ready", int'(irdy[0]), 1);
    end
    @(negedge clk);
    chk("drain_valid", int'(ov[0]), 0);
    chk("drain_count", int'(cnt[0]), 0);

    // Streaming 0..99.
    #1 iv[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      id[0] = 8'(k);
      @(negedge clk);
      if (k == 60) begin
        chk("stream_count", int'(cnt[0]), 3);
        chk("stream_valid", int'(ov[0]), 1);
        chk("stream_data", int'(od[0]), 58);
      end
      #1;
    end
    iv[0] = 1'b0;
    repeat (6) @(negedge clk);

    // Reset mid-operation with three words held.
    #1 ordy[0] = 1'b0; iv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id[0] = 8'(5 + k);
      @(negedge clk);
      #1;
    end
    iv[0] = 1'b0;
    chk("midrst_count_before", int'(cnt[0]), 3);
    rst = 1'b1;
    #1;
    chk("midrst_async_valid", int'(ov[0]), 0);
    chk("midrst_async_count", int'(cnt[0]), 0);
    @(negedge clk);
    #1 rst = 1'b0; ordy[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_valid", int'(ov[0]), 0);
    end

    // Random traffic on all instances.
    #1 iv = '0; rdy_seen = irdy;
    pin = 50; pout = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        pin  = int'($urandom_range(20, 100));
        pout = int'($urandom_range(10, 100));
      end
      for (int g = 0; g < N; g++) begin
        if (!iv[g] || rdy_seen[g]) begin
          iv[g] = ($urandom_range(0, 99) < pin);
          id[g] = 8'($urandom);
        end
        ordy[g] = ($urandom_range(0, 99) < pout);
      end
      rdy_seen = irdy;
      @(negedge clk);
      #1;
    end
    iv = '0; ordy = '1;
    repeat (10) @(negedge clk);
    for (int g = 0; g < N; g++) chk("final_empty", int'(cnt[g]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
